// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: bypass selects and writeback selects.
package hazard_pkg;

   localparam logic [1:0] NONE    = 2'b00;
   localparam logic [1:0] RESULTW = 2'b01;
   localparam logic [1:0] ALUM    = 2'b10;

   localparam logic [1:0] WBMEM   = 2'b01;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits for long-latency (MDU) writes, plus a saturating
// count of writes still in flight.
module reg_scoreboard #(
   parameter int unsigned REG_W    = 5,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned MAX_LONG = 2,
   parameter int unsigned OUT_W    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                issue,
   input  logic [REG_W-1:0]    issueRd,
   input  logic                done,
   input  logic [REG_W-1:0]    doneRd,
   output logic [NUM_REGS-1:0] pending,
   output logic [OUT_W-1:0]    outstanding
);

   localparam logic [OUT_W-1:0] MaxOut = OUT_W'(MAX_LONG);

   logic [NUM_REGS-1:0] pendingQ, pendingD;
   logic [OUT_W-1:0]    outQ, outD;
   logic                clearHit;

   always_comb begin
      pendingD = pendingQ;
      // A completion only retires an in-flight write if the same edge does not re-issue it.
      clearHit = done && pendingQ[doneRd] && !(issue && (issueRd == doneRd));
      if (done) begin
         pendingD[doneRd] = 1'b0;
      end
      if (issue) begin
         pendingD[issueRd] = 1'b1;
      end
      pendingD[0] = 1'b0;
   end

   always_comb begin
      outD = outQ;
      if (issue && !clearHit) begin
         if (outQ != MaxOut) begin
            outD = outQ + 1'b1;
         end
      end else if (clearHit && !issue) begin
         if (outQ != '0) begin
            outD = outQ - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pendingQ <= '0;
         outQ     <= '0;
      end else begin
         pendingQ <= pendingD;
         outQ     <= outD;
      end
   end

   assign pending     = pendingQ;
   assign outstanding = outQ;

endmodule

// File: rtl/hazard_unit_sb.sv
// Pipeline hazard unit: M/W bypass selection, load-use / branch / scoreboard
// stall detection, and a saturating count of stalled cycles.
module hazard_unit_sb
   import hazard_pkg::*;
#(
   parameter int unsigned REG_W    = 5,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned MAX_LONG = 2,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [REG_W-1:0]    adr1D,
   input  logic [REG_W-1:0]    adr2D,
   input  logic [REG_W-1:0]    rdD,
   input  logic                RegWriteD,
   input  logic                longD,
   input  logic                branchD,
   input  logic                jumpD,
   input  logic [REG_W-1:0]    adr1E,
   input  logic [REG_W-1:0]    adr2E,
   input  logic [REG_W-1:0]    rdE,
   input  logic [1:0]          WB_SelE,
   input  logic                RegWriteE,
   input  logic                longE,
   input  logic [REG_W-1:0]    rdM,
   input  logic [REG_W-1:0]    rdW,
   input  logic                RegWriteM,
   input  logic                RegWriteW,
   input  logic                long_done,
   input  logic [REG_W-1:0]    long_rd,
   output logic                StallF,
   output logic                StallD,
   output logic                FlushE,
   output logic [1:0]          Forward1D,
   output logic [1:0]          Forward2D,
   output logic [1:0]          Forward1E,
   output logic [1:0]          Forward2E,
   output logic [NUM_REGS-1:0] pending,
   output logic [CNT_W-1:0]    stall_cnt
);

   localparam int unsigned      OUT_W  = $clog2(MAX_LONG + 1);
   localparam logic [OUT_W-1:0] MaxOut = OUT_W'(MAX_LONG);

   logic             issue;
   logic [OUT_W-1:0] outstanding;
   logic             srcHitE, loadUse, branchHaz, jumpHaz, rawHaz, wawHaz, structHaz;
   logic             stallCond;
   logic [CNT_W-1:0] stallCntQ, stallCntD;

   function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] adr,
                                         input logic [REG_W-1:0] mRd, input logic mWe,
                                         input logic [REG_W-1:0] wRd, input logic wWe);
      if (adr != '0 && adr == mRd && mWe) begin
         return ALUM;
      end else if (adr != '0 && adr == wRd && wWe) begin
         return RESULTW;
      end
      return NONE;
   endfunction

   assign issue = longE && RegWriteE && (rdE != '0);

   reg_scoreboard #(
      .REG_W   (REG_W),
      .NUM_REGS(NUM_REGS),
      .MAX_LONG(MAX_LONG),
      .OUT_W   (OUT_W)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .issue      (issue),
      .issueRd    (rdE),
      .done       (long_done),
      .doneRd     (long_rd),
      .pending    (pending),
      .outstanding(outstanding)
   );

   // Scoreboard terms read the registered bits, so a completion frees the stall one cycle later.
   always_comb begin
      srcHitE   = ((adr1D == rdE) || (adr2D == rdE)) && (rdE != '0);
      loadUse   = srcHitE && (WB_SelE == WBMEM);
      branchHaz = (branchD || jumpD) && RegWriteE && srcHitE;
      jumpHaz   = jumpD && RegWriteE;
      rawHaz    = ((adr1D != '0) && pending[adr1D]) || ((adr2D != '0) && pending[adr2D]);
      wawHaz    = RegWriteD && pending[rdD];
      structHaz = longD && (outstanding == MaxOut);
      stallCond = loadUse || branchHaz || jumpHaz || rawHaz || wawHaz || structHaz;
   end

   always_comb begin
      StallF    = stallCond && !rst;
      StallD    = stallCond && !rst;
      FlushE    = stallCond && !rst;
      Forward1D = rst ? NONE : fwdSel(adr1D, rdM, RegWriteM, rdW, RegWriteW);
      Forward2D = rst ? NONE : fwdSel(adr2D, rdM, RegWriteM, rdW, RegWriteW);
      Forward1E = rst ? NONE : fwdSel(adr1E, rdM, RegWriteM, rdW, RegWriteW);
      Forward2E = rst ? NONE : fwdSel(adr2E, rdM, RegWriteM, rdW, RegWriteW);
   end

   always_comb begin
      stallCntD = stallCntQ;
      if (stallCond && (stallCntQ != '1)) begin
         stallCntD = stallCntQ + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stallCntQ <= '0;
      end else begin
         stallCntQ <= stallCntD;
      end
   end

   assign stall_cnt = stallCntQ;

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed bench for hazard_unit_sb: expectations are queued by the stimulus
// process and checked by an independent negedge monitor.
module tb_hazard_unit_sb;
   import hazard_pkg::*;

   localparam int unsigned RW = 5;
   localparam int unsigned NR = 32;
   localparam int unsigned ML = 2;
   localparam int unsigned CW = 4;

   localparam int KStall = 0;
   localparam int KF1E   = 1;
   localparam int KF2E   = 2;
   localparam int KF1D   = 3;
   localparam int KF2D   = 4;
   localparam int KPend  = 5;
   localparam int KCnt   = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic [RW-1:0] adr1D, adr2D, rdD, adr1E, adr2E, rdE, rdM, rdW, long_rd;
   logic          RegWriteD, longD, branchD, jumpD, RegWriteE, longE;
   logic          RegWriteM, RegWriteW, long_done;
   logic [1:0]    WB_SelE;
   logic          StallF, StallD, FlushE;
   logic [1:0]    Forward1D, Forward2D, Forward1E, Forward2E;
   logic [NR-1:0] pending;
   logic [CW-1:0] stall_cnt;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] exp;
   } item_t;

   item_t       q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] expCnt = 0;
   logic [31:0] expPend = 0;

   hazard_unit_sb #(
      .REG_W   (RW),
      .NUM_REGS(NR),
      .MAX_LONG(ML),
      .CNT_W   (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .adr1D    (adr1D),
      .adr2D    (adr2D),
      .rdD      (rdD),
      .RegWriteD(RegWriteD),
      .longD    (longD),
      .branchD  (branchD),
      .jumpD    (jumpD),
      .adr1E    (adr1E),
      .adr2E    (adr2E),
      .rdE      (rdE),
      .WB_SelE  (WB_SelE),
      .RegWriteE(RegWriteE),
      .longE    (longE),
      .rdM      (rdM),
      .rdW      (rdW),
      .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW),
      .long_done(long_done),
      .long_rd  (long_rd),
      .StallF   (StallF),
      .StallD   (StallD),
      .FlushE   (FlushE),
      .Forward1D(Forward1D),
      .Forward2D(Forward2D),
      .Forward1E(Forward1E),
      .Forward2E(Forward2E),
      .pending  (pending),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin : monitor
      item_t       it;
      logic [31:0] act;
      while (q.size() > 0) begin
         it = q.pop_front();
         case (it.kind)
            KStall:  act = {29'b0, StallF, StallD, FlushE};
            KF1E:    act = {30'b0, Forward1E};
            KF2E:    act = {30'b0, Forward2E};
            KF1D:    act = {30'b0, Forward1D};
            KF2D:    act = {30'b0, Forward2D};
            KPend:   act = pending;
            KCnt:    act = {28'b0, stall_cnt};
            default: act = 'x;
         endcase
         checks++;
         if (act !== it.exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", it.name, act, it.exp);
         end
      end
   end

   task automatic push(input string n, input int k, input logic [31:0] e);
      item_t it;
      it.name = n;
      it.kind = k;
      it.exp  = e;
      q.push_back(it);
   endtask

   task automatic chkStall(input string n, input bit s);
      push(n, KStall, s ? 32'h7 : 32'h0);
      push({n, "_cnt"}, KCnt, expCnt);
      if (s && expCnt != 32'd15) expCnt = expCnt + 1;
   endtask

   task automatic chkPend(input string n);
      push(n, KPend, expPend);
   endtask

   task automatic clrIn();
      adr1D = '0; adr2D = '0; rdD = '0; RegWriteD = 0; longD = 0; branchD = 0; jumpD = 0;
      adr1E = '0; adr2E = '0; rdE = '0; WB_SelE = NONE; RegWriteE = 0; longE = 0;
      rdM = '0; rdW = '0; RegWriteM = 0; RegWriteW = 0; long_done = 0; long_rd = '0;
   endtask

   task automatic nextCyc();
      @(posedge clk);
      #1;
      clrIn();
   endtask

   initial begin
      rst = 1'b1;
      clrIn();
      // Reset: outputs gated even with hazard/forward-inducing inputs.
      nextCyc();
      jumpD = 1; RegWriteE = 1; adr1E = 5; rdM = 5; RegWriteM = 1;
      chkStall("rst_stall", 0); push("rst_f1e", KF1E, NONE); chkPend("rst_pend");

      nextCyc(); rst = 0;
      chkStall("idle", 0); chkPend("idle_pend");

      // Forwarding: M beats W, zero source never forwards.
      nextCyc();
      adr1E = 5; rdM = 5; RegWriteM = 1; rdW = 5; RegWriteW = 1; adr2D = 5;
      push("f1e_alum", KF1E, ALUM); push("f2d_alum", KF2D, ALUM); push("f1d_zero", KF1D, NONE);
      nextCyc();
      rdM = 5; rdW = 6; RegWriteW = 1; adr2E = 6; adr1D = 5; adr2D = 6;
      push("f1e_zero", KF1E, NONE); push("f2e_resw", KF2E, RESULTW);
      push("f1d_mdis", KF1D, NONE); push("f2d_resw", KF2D, RESULTW);

      // Load-use: one stall cycle.
      nextCyc(); WB_SelE = WBMEM; rdE = 7; RegWriteE = 1; adr2D = 7;
      chkStall("loaduse", 1);
      nextCyc(); chkStall("loaduse_rel", 0);

      // RAW on long write; completion releases a cycle later.
      nextCyc(); longE = 1; RegWriteE = 1; rdE = 9; chkStall("iss9", 0);
      nextCyc(); adr1D = 9; expPend = 32'h1 << 9; chkPend("pend9"); chkStall("raw9", 1);
      nextCyc(); adr1D = 9; long_done = 1; long_rd = 9; chkStall("raw9_done", 1);
      nextCyc(); adr1D = 9; expPend = 0; chkPend("clr9"); chkStall("raw9_rel", 0);

      // Structural limit.
      nextCyc(); longE = 1; RegWriteE = 1; rdE = 3; chkStall("iss3", 0);
      nextCyc(); longE = 1; RegWriteE = 1; rdE = 4; expPend = 32'h8; chkPend("pend3");
      chkStall("iss4", 0);
      nextCyc(); longD = 1; expPend = 32'h18; chkPend("pend34"); chkStall("struct_full", 1);
      nextCyc(); longD = 1; long_done = 1; long_rd = 3; chkStall("struct_done", 1);
      nextCyc(); longD = 1; expPend = 32'h10; chkPend("pend4"); chkStall("struct_rel", 0);
      nextCyc(); longE = 1; RegWriteE = 1; rdE = 3; chkStall("reiss3", 0);
      nextCyc(); longE = 1; RegWriteE = 1; rdE = 5; long_done = 1; long_rd = 3;
      expPend = 32'h18; chkPend("pend34b"); chkStall("iss5_done3", 0);
      nextCyc(); longD = 1; expPend = 32'h30; chkPend("pend45"); chkStall("out_held", 1);
      nextCyc(); longD = 1; long_done = 1; long_rd = 4; chkStall("done4", 1);
      nextCyc(); longD = 1; long_done = 1; long_rd = 3; expPend = 32'h20; chkPend("pend5");
      chkStall("out_one", 0);
      nextCyc(); longD = 1; chkPend("stray_done"); chkStall("stray_out", 0);

      // Same-edge issue/completion; WAW; branch/jump terms.
      nextCyc(); longE = 1; RegWriteE = 1; rdE = 6; long_done = 1; long_rd = 6;
      chkStall("iss6_done6", 0);
      nextCyc(); RegWriteD = 1; rdD = 6; expPend = 32'h60; chkPend("set_wins");
      chkStall("waw6", 1);
      nextCyc(); branchD = 1; RegWriteE = 1; rdE = 8; adr1D = 8; chkStall("branch", 1);
      nextCyc(); jumpD = 1; RegWriteE = 1; chkStall("jump", 1);
      nextCyc(); branchD = 1; rdE = 8; adr1D = 8; chkStall("branch_nowe", 0);
      nextCyc(); WB_SelE = WBMEM; chkStall("load_x0", 0);

      // Reset mid-operation.
      nextCyc(); rst = 1; jumpD = 1; RegWriteE = 1; adr1E = 5; rdM = 5; RegWriteM = 1;
      adr1D = 6; push("rst_mid_stall", KStall, 0); push("rst_mid_f1e", KF1E, NONE);
      push("rst_mid_f1d", KF1D, NONE);
      expCnt = 0; expPend = 0;
      nextCyc(); rst = 0; chkPend("post_rst_pend"); chkStall("post_rst", 0);
      nextCyc(); adr1D = 6; long_done = 1; long_rd = 6; chkStall("post_rst_raw", 0);
      nextCyc(); longD = 1; chkPend("post_rst_pend2"); chkStall("post_rst_struct", 0);

      // Saturation of the 4-bit stall counter.
      for (int i = 0; i < (1 << CW) + 3; i++) begin
         nextCyc(); jumpD = 1; RegWriteE = 1; chkStall($sformatf("sat%0d", i), 1);
      end
      nextCyc(); chkStall("sat_end", 0);
      nextCyc(); chkStall("sat_hold", 0);

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
